survivor_path_ctrl: RTL and testbench
=====================================

# survivor_path_ctrl

Sequencing controller for the 20-stage register-exchange survivor path of the Viterbi decoder. Accepts per-step ACS decision vectors and best-state indices over a valid/ready handshake and drives the survivor path's enable and data input. Selects one decoded bit per step from the survivor output, tracks chain fill, and flushes the chain with zero-state tail steps at frame end. Emits exactly one decoded bit per accepted decision, with `out_last` on the frame's final bit.

## Interface
- `DEPTH`, 20: number of survivor path stages; must match the instantiated chain.
- `NSTATE`, 8: trellis states, equal to the decision/survivor vector width.
- `SW`, 3: best-state index width, $clog2(NSTATE).
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  decision vector and best state are valid.
- `in_ready`  out  1  controller accepts the input this cycle.
- `in_dec`  in  NSTATE  ACS decision vector for this trellis step.
- `in_best`  in  SW  index of the minimum-metric state for this step.
- `in_last`  in  1  this step is the last of the frame.
- `sp_enable`  out  1  advance the survivor path by one step.
- `sp_data_in`  out  NSTATE  decision vector fed to the survivor path.
- `sp_data_out`  in  NSTATE  survivor path output (oldest stage).
- `out_valid`  out  1  decoded bit is valid.
- `out_ready`  in  1  downstream accepts the decoded bit.
- `out_bit`  out  1  decoded bit.
- `out_last`  out  1  final decoded bit of the frame.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- States are IDLE, FILL, RUN and FLUSH. `occ` counts filled chain stages and runs 0..DEPTH. `fl_cnt` counts flush steps and runs 0..DEPTH-1.
- `in_ready = (state != FLUSH) && (!out_valid || out_ready)`. A handshake is `accept = in_valid && in_ready`.
- On accept, `sp_enable` is high and `sp_data_in = in_dec`, both combinational in the same cycle.
- Emission rule: a step emits a bit only when `occ == DEPTH` before the step.
  - On an emitting step, `out_bit <= sp_data_out[sel]`, sampled from the pre-edge value.
  - `sel = in_best` for accepted steps and `sel = 0` for flush steps.
  - On a non-emitting step, `occ` increments.
- State transitions:
  - IDLE goes to FILL on accept.
  - FILL goes to RUN when `occ` reaches DEPTH.
  - FILL or RUN goes to FLUSH on an accept with `in_last`. That step is processed normally first.
  - An accept in IDLE with `in_last` (1-step frame) goes directly to FLUSH.
- FLUSH behaviour:
  - A step is taken when `!out_valid || out_ready`.
  - Each step drives `sp_enable = 1` and `sp_data_in = 0`, i.e. the zero-terminated tail.
  - A step emits only if `occ == DEPTH`, otherwise it increments `occ`.
  - After exactly DEPTH flush steps the state returns to IDLE, and `occ` and `fl_cnt` clear.
  - The last flush step always emits and sets `out_last = 1`.
- Bit count: total emitted bits = N accepted steps, for any N ≥ 1, including N < DEPTH.
- Output register is one entry deep:
  - `out_valid` sets on an emitting step.
  - `out_valid` clears on `out_valid && out_ready` when no new emission happens in the same cycle.
  - A simultaneous drain and emit keeps `out_valid = 1` and loads the new bit.
- Stale chain contents are never emitted, because emission is gated by `occ`. The survivor path needs no clear between frames.

## Timing
- Reset (`rst = 0`, asynchronous) forces:
  - state IDLE, `occ = 0`, `fl_cnt = 0`;
  - `out_valid = 0`, `out_bit = 0`, `out_last = 0`, `busy = 0`;
  - `sp_enable = 0`, `sp_data_in = 0`.
- Reset mid-frame drops the frame silently; the next accept starts a new frame.
- Latency:
  - The first bit of a frame appears the cycle after the (DEPTH+1)-th accept.
  - For frames with N ≤ DEPTH, the first bit appears in FLUSH instead.
- Throughput is one step per cycle when `out_ready` is held high.
- Backpressure: while `out_valid && !out_ready`, `in_ready = 0` and FLUSH stalls. `sp_enable` stays low and the chain holds.
- While `in_valid = 0`, `sp_enable = 0`, and `in_best` is ignored.
- `in_last` is ignored unless accepted.
- No input is accepted during FLUSH. A new frame may be accepted the cycle after the return to IDLE.

## Structure
- Package `viterbi_pkg` holds:
  - `DEPTH_C = 20`, `NSTATE_C = 8`;
  - `typedef logic [NSTATE_C-1:0] dec_t`;
  - `typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} sp_state_t`.
- No sub-module: a single FSM with two counters and the output register.
- The existing `survivor_path` is instantiated alongside this block at the decoder top, not inside it.

## Test plan
- Continuous frame: N=50 accepts, `out_ready=1`.
  - No `out_valid` before the 21st accept, then exactly 50 bits total.
  - `out_last` set only on bit 50; `busy` falls the cycle after the final flush step.
- Short frame: N=5 accepts, the last with `in_last`.
  - FLUSH runs 20 steps with `sp_data_in=0` and the first 15 steps are non-emitting.
  - Exactly 5 bits out; bit 5 carries `out_last`.
- Single-step frame: one accept with `in_last` from IDLE.
  - Goes straight to FLUSH; exactly 1 bit out, with `out_last=1`.
- Backpressure: hold `out_ready=0` for 7 cycles during RUN.
  - `in_ready=0` and `sp_enable=0` throughout; `out_bit` holds its value.
  - After release, no bit is lost or duplicated compared against a golden model.
- Reset mid-frame: `rst` low for 1 cycle during RUN.
  - All outputs are 0 immediately (asynchronous).
  - A following 30-step frame decodes correctly, with the first bit after accept 21.
- Bit selection: drive `in_best=5` and `sp_data_out=8'b0010_0000` on an emitting step → `out_bit=1`. With `in_best=4` → `out_bit=0`.

Source files
------------

// File: rtl/viterbi_pkg.sv
// Shared constants and types for the Viterbi survivor-path sequencing logic.
package viterbi_pkg;
   localparam int DEPTH_C  = 20;
   localparam int NSTATE_C = 8;

   typedef logic [NSTATE_C-1:0] dec_t;

   typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} sp_state_t;
endpackage

// File: rtl/survivor_path_ctrl_if.sv
// Handshake and survivor-path bundle between the controller (slave) and its environment (master).
interface survivor_path_ctrl_if
   import viterbi_pkg::*;
#(
   parameter int NSTATE = NSTATE_C,
   parameter int SW     = $clog2(NSTATE)
) ();
   logic              in_valid;
   logic              in_ready;
   logic [NSTATE-1:0] in_dec;
   logic [SW-1:0]     in_best;
   logic              in_last;
   logic              sp_enable;
   logic [NSTATE-1:0] sp_data_in;
   logic [NSTATE-1:0] sp_data_out;
   logic              out_valid;
   logic              out_ready;
   logic              out_bit;
   logic              out_last;
   logic              busy;

   modport slave (
      input  in_valid, in_dec, in_best, in_last, sp_data_out, out_ready,
      output in_ready, sp_enable, sp_data_in, out_valid, out_bit, out_last, busy
   );

   modport master (
      output in_valid, in_dec, in_best, in_last, sp_data_out, out_ready,
      input  in_ready, sp_enable, sp_data_in, out_valid, out_bit, out_last, busy
   );
endinterface

// File: rtl/survivor_path_ctrl.sv
// Sequences the register-exchange survivor path: feeds decisions, tracks chain fill,
// flushes with zero-state tail steps and emits one decoded bit per accepted step.
module survivor_path_ctrl
   import viterbi_pkg::*;
#(
   parameter int DEPTH  = DEPTH_C,
   parameter int NSTATE = NSTATE_C,
   parameter int SW     = $clog2(NSTATE)
) (
   input  logic                 clk,
   input  logic                 rst,
   survivor_path_ctrl_if.slave  sp_if
);
   localparam int            CW     = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] C_FULL = CW'(DEPTH);
   localparam logic [CW-1:0] C_LAST = CW'(DEPTH - 1);

   sp_state_t     r_state, w_state_next;
   logic [CW-1:0] r_occ, w_occ_next;
   logic [CW-1:0] r_fl_cnt, w_fl_cnt_next;
   logic          r_out_valid, r_out_bit, r_out_last;

   logic          w_can_step, w_accept, w_flush_step, w_step, w_emit, w_flush_done;
   logic [SW-1:0] w_sel;

   // Gating with rst keeps the chain frozen while reset is asserted.
   assign w_can_step   = rst && (!r_out_valid || sp_if.out_ready);
   assign w_accept     = sp_if.in_valid && sp_if.in_ready;
   assign w_flush_step = (r_state == FLUSH) && w_can_step;
   assign w_step       = w_accept || w_flush_step;
   assign w_emit       = w_step && (r_occ == C_FULL);
   assign w_flush_done = w_flush_step && (r_fl_cnt == C_LAST);
   assign w_sel        = w_accept ? sp_if.in_best : '0;

   assign sp_if.in_ready   = (r_state != FLUSH) && w_can_step;
   assign sp_if.sp_enable  = w_step;
   assign sp_if.sp_data_in = w_accept ? sp_if.in_dec : '0;
   assign sp_if.out_valid  = r_out_valid;
   assign sp_if.out_bit    = r_out_bit;
   assign sp_if.out_last   = r_out_last;
   assign sp_if.busy       = (r_state != IDLE);

   always_comb begin
      w_state_next  = r_state;
      w_occ_next    = r_occ;
      w_fl_cnt_next = r_fl_cnt;
      if (w_step && !w_emit)
         w_occ_next = r_occ + 1'b1;
      if (w_flush_step)
         w_fl_cnt_next = r_fl_cnt + 1'b1;
      case (r_state)
         IDLE:
            if (w_accept)
               w_state_next = sp_if.in_last ? FLUSH : FILL;
         FILL:
            if (w_accept) begin
               if (sp_if.in_last)
                  w_state_next = FLUSH;
               else if (r_occ == C_LAST)
                  w_state_next = RUN;
            end
         RUN:
            if (w_accept && sp_if.in_last)
               w_state_next = FLUSH;
         FLUSH:
            if (w_flush_done) begin
               w_state_next  = IDLE;
               w_occ_next    = '0;
               w_fl_cnt_next = '0;
            end
         default:
            w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= IDLE;
         r_occ       <= '0;
         r_fl_cnt    <= '0;
         r_out_valid <= 1'b0;
         r_out_bit   <= 1'b0;
         r_out_last  <= 1'b0;
      end else begin
         r_state  <= w_state_next;
         r_occ    <= w_occ_next;
         r_fl_cnt <= w_fl_cnt_next;
         // A drain and a new emission in the same cycle simply reload the register.
         if (w_emit) begin
            r_out_valid <= 1'b1;
            r_out_bit   <= sp_if.sp_data_out[w_sel];
            r_out_last  <= w_flush_done;
         end else if (r_out_valid && sp_if.out_ready) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_survivor_path_ctrl.sv
// Directed bench for survivor_path_ctrl with a behavioural survivor chain and golden bit model.
module tb_survivor_path_ctrl;
   import viterbi_pkg::*;

   localparam int DEPTH  = DEPTH_C;
   localparam int NSTATE = NSTATE_C;
   localparam int SW     = $clog2(NSTATE);

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   survivor_path_ctrl_if #(.NSTATE(NSTATE), .SW(SW)) sp_if ();

   survivor_path_ctrl #(.DEPTH(DEPTH), .NSTATE(NSTATE), .SW(SW)) dut (
      .clk   (clk),
      .rst   (rst),
      .sp_if (sp_if)
   );

   // Behavioural register-exchange chain: stage 0 newest, stage DEPTH-1 oldest.
   dec_t chain [DEPTH];
   logic ovr_en  = 1'b0;
   dec_t ovr_val = '0;
   always @(posedge clk) begin
      if (sp_if.sp_enable) begin
         for (int i = DEPTH - 1; i > 0; i--)
            chain[i] <= chain[i-1];
         chain[0] <= sp_if.sp_data_in;
      end
   end
   assign sp_if.sp_data_out = ovr_en ? ovr_val : chain[DEPTH-1];

   int n_cmp = 0;
   int n_err = 0;

   dec_t          dec_a  [64];
   logic [SW-1:0] best_a [64];
   logic          exp_b  [64];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drives one frame of n steps; optional output stall window and mid-frame reset.
   task automatic run_frame(input int n, input int stall_at, input int stall_len, input int rst_at);
      int            acc, got, cyc, first_acc, flush_steps;
      logic          held, stalled;
      logic [SW-1:0] sel;
      acc = 0; got = 0; cyc = 0; first_acc = -1; flush_steps = 0; held = 1'b0;
      for (int k = 0; k < n; k++) begin
         dec_a[k]  = dec_t'($urandom);
         best_a[k] = SW'($urandom_range(0, NSTATE - 1));
      end
      for (int k = 0; k < n; k++) begin
         sel      = (k + DEPTH < n) ? best_a[k+DEPTH] : '0;
         exp_b[k] = dec_a[k][sel];
      end
      while (got < n && cyc < 4 * n + 4 * DEPTH + 50) begin
         stalled = (stall_at >= 0) && (cyc >= stall_at) && (cyc < stall_at + stall_len);
         sp_if.out_ready = !stalled;
         sp_if.in_valid  = (acc < n);
         sp_if.in_dec    = (acc < n) ? dec_a[acc] : '0;
         sp_if.in_best   = (acc < n) ? best_a[acc] : '0;
         sp_if.in_last   = (acc == n - 1);
         #1;
         if (cyc == rst_at) begin
            rst = 1'b0;
            #1;
            chk("rst_out_valid", sp_if.out_valid, 0);
            chk("rst_out_bit", sp_if.out_bit, 0);
            chk("rst_out_last", sp_if.out_last, 0);
            chk("rst_busy", sp_if.busy, 0);
            chk("rst_sp_enable", sp_if.sp_enable, 0);
            chk("rst_sp_data_in", sp_if.sp_data_in, 0);
            @(negedge clk);
            rst = 1'b1;
            sp_if.in_valid = 1'b0;
            $display("frame n=%0d aborted by reset after %0d accepts", n, acc);
            return;
         end
         if (stalled) begin
            if (cyc == stall_at) held = sp_if.out_bit;
            chk("stall_out_valid", sp_if.out_valid, 1);
            chk("stall_in_ready", sp_if.in_ready, 0);
            chk("stall_sp_enable", sp_if.sp_enable, 0);
            chk("stall_out_bit_hold", sp_if.out_bit, held);
         end
         if (sp_if.out_valid && first_acc < 0) begin
            first_acc = acc;
            if (n > DEPTH) chk("first_bit_accepts", acc, DEPTH + 1);
            else           chk("first_bit_flush_steps", flush_steps, DEPTH - n + 1);
         end
         if (sp_if.out_valid && sp_if.out_ready) begin
            chk("out_bit", sp_if.out_bit, exp_b[got]);
            chk("out_last", sp_if.out_last, (got == n - 1));
            chk("busy_at_bit", sp_if.busy, (got != n - 1));
            got++;
         end
         if (sp_if.in_valid && sp_if.in_ready) begin
            chk("accept_sp_enable", sp_if.sp_enable, 1);
            chk("accept_sp_data_in", sp_if.sp_data_in, dec_a[acc]);
            acc++;
         end else if (acc == n && sp_if.sp_enable) begin
            chk("flush_sp_data_in", sp_if.sp_data_in, 0);
            flush_steps++;
         end
         @(negedge clk);
         cyc++;
      end
      sp_if.in_valid = 1'b0;
      #1;
      chk("bits_received", got, n);
      chk("flush_steps", flush_steps, DEPTH);
      chk("end_out_valid", sp_if.out_valid, 0);
      chk("end_busy", sp_if.busy, 0);
      $display("frame n=%0d: %0d accepts, %0d bits, %0d flush steps", n, acc, got, flush_steps);
      @(negedge clk);
   endtask

   initial begin
      sp_if.in_valid  = 1'b1;
      sp_if.in_dec    = 8'hA5;
      sp_if.in_best   = '0;
      sp_if.in_last   = 1'b0;
      sp_if.out_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("reset_out_valid", sp_if.out_valid, 0);
      chk("reset_busy", sp_if.busy, 0);
      chk("reset_sp_enable", sp_if.sp_enable, 0);
      chk("reset_sp_data_in", sp_if.sp_data_in, 0);
      sp_if.in_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);

      run_frame(50, -1, 0, -1);
      run_frame(5, -1, 0, -1);
      run_frame(1, -1, 0, -1);
      run_frame(50, 30, 7, -1);
      run_frame(40, -1, 0, 28);
      run_frame(30, -1, 0, -1);

      // Bit selection with a forced survivor output on emitting steps.
      sp_if.out_ready = 1'b1;
      sp_if.in_last   = 1'b0;
      sp_if.in_best   = '0;
      for (int k = 0; k < DEPTH; k++) begin
         sp_if.in_valid = 1'b1;
         sp_if.in_dec   = dec_t'($urandom);
         @(negedge clk);
      end
      ovr_en = 1'b1;
      ovr_val = 8'b0010_0000;
      sp_if.in_best = 3'd5;
      @(negedge clk);
      chk("sel5_out_valid", sp_if.out_valid, 1);
      chk("sel5_out_bit", sp_if.out_bit, 1);
      $display("bit select best=5 data=%b -> out_bit=%0b", ovr_val, sp_if.out_bit);
      sp_if.in_best = 3'd4;
      @(negedge clk);
      chk("sel4_out_bit", sp_if.out_bit, 0);
      $display("bit select best=4 data=%b -> out_bit=%0b", ovr_val, sp_if.out_bit);
      ovr_en = 1'b0;
      sp_if.in_last = 1'b1;
      @(negedge clk);
      sp_if.in_valid = 1'b0;
      sp_if.in_last  = 1'b0;
      for (int c = 0; c < 100 && sp_if.busy; c++)
         @(negedge clk);
      chk("final_idle", sp_if.busy, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
